// File: rtl/tree_cmd_scheduler_if.sv
// rtl/tree_cmd_scheduler_if.sv - requester, response and tree-command bundle for tree_cmd_scheduler
interface tree_cmd_scheduler_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 7
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);

  logic [NUM_REQ-1:0]            req_valid;
  logic [2*NUM_REQ-1:0]          req_op;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          tq_wrt;
  logic                          tq_read;
  logic [DATA_WIDTH-1:0]         tq_data;
  logic [DATA_WIDTH-1:0]         tq_root;
  logic [CNT_W-1:0]              count;

  // Requesters plus the heap tree: drive requests, accept responses, supply the root.
  modport master (
    output req_valid, req_op, req_data, rsp_ready, tq_root,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, tq_wrt, tq_read, tq_data, count
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_op, req_data, rsp_ready, tq_root,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, tq_wrt, tq_read, tq_data, count
  );
endinterface

// File: rtl/tree_cmd_scheduler.sv
// rtl/tree_cmd_scheduler.sv - round-robin command scheduler in front of the pipelined BRAM heap tree
module tree_cmd_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 7,
  parameter int ISSUE_GAP  = 4
) (
  input logic               CLK,
  input logic               RSTn,
  tree_cmd_scheduler_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int GAP_W = $clog2(ISSUE_GAP + 1);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_REJECT, S_RESP, S_GAP
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       winner;
  logic [GAP_W-1:0]      gap_cnt;
  logic [ID_W-1:0]       pick;
  logic                  found;
  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  illegal;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // Mux out the granted requester's op/key and decide legality against current occupancy.
  always_comb begin
    sel_op    = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_op    = bus.req_op[2*i +: 2];
        sel_data  = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
        sel_valid = bus.req_valid[i];
      end
    end
    illegal = (sel_op == 2'b00) ||
              (sel_op == OP_POP  && bus.count == '0) ||
              (sel_op == OP_PUSH && bus.count == CNT_W'(QUEUE_SIZE));
  end

  // Main FSM: all outputs registered; tq_* default low so every tree command is a one-cycle pulse.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      winner        <= '0;
      gap_cnt       <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.tq_wrt    <= 1'b0;
      bus.tq_read   <= 1'b0;
      bus.tq_data   <= '0;
      bus.count     <= '0;
    end else begin
      bus.tq_wrt  <= 1'b0;
      bus.tq_read <= 1'b0;
      bus.tq_data <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            winner        <= pick;
            bus.req_ready <= NUM_REQ'(1) << pick;
            state         <= S_GRANT;
          end
        end
        S_GRANT: begin
          bus.req_ready <= '0;
          rr_ptr        <= ID_W'((int'(winner) + 1) % NUM_REQ);
          if (!sel_valid) begin
            state <= S_IDLE;
          end else if (illegal) begin
            state <= S_REJECT;
          end else begin
            bus.tq_wrt  <= sel_op[0];
            bus.tq_read <= sel_op[1];
            bus.tq_data <= sel_data;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Root seen this cycle is the value before the tree applies the command.
          bus.rsp_data  <= bus.tq_read ? bus.tq_root : '0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_id    <= winner;
          bus.rsp_valid <= 1'b1;
          gap_cnt       <= GAP_W'(ISSUE_GAP);
          if (bus.tq_wrt && !bus.tq_read)
            bus.count <= bus.count + CNT_W'(1);
          else if (!bus.tq_wrt && bus.tq_read)
            bus.count <= bus.count - CNT_W'(1);
          else if (bus.count == '0 && bus.tq_data != '0)
            bus.count <= CNT_W'(1);
          state <= S_RESP;
        end
        S_REJECT: begin
          bus.rsp_data  <= '0;
          bus.rsp_err   <= 1'b1;
          bus.rsp_id    <= winner;
          bus.rsp_valid <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          // Spacing counter keeps running while the response waits.
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= (gap_cnt <= GAP_W'(1)) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tree_cmd_scheduler.sv
// tb/tb_tree_cmd_scheduler.sv - randomized self-checking bench for tree_cmd_scheduler
module tb_tree_cmd_scheduler;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  tree_cmd_scheduler_if #(.NUM_REQ(2), .DATA_WIDTH(16), .QUEUE_SIZE(7)) bus ();

  tree_cmd_scheduler #(.NUM_REQ(2), .DATA_WIDTH(16), .QUEUE_SIZE(7), .ISSUE_GAP(4)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural heap tree: sorted ascending, root is the largest key (0 when empty).
  int tree_q[$];
  always @(posedge CLK) begin
    if (!RSTn) begin
      tree_q.delete();
      bus.tq_root <= '0;
    end else begin
      if (bus.tq_wrt && !bus.tq_read) begin
        tree_q.push_back(int'(bus.tq_data));
        tree_q.sort();
      end else if (!bus.tq_wrt && bus.tq_read) begin
        if (tree_q.size() > 0) void'(tree_q.pop_back());
      end else if (bus.tq_wrt && bus.tq_read) begin
        if (tree_q.size() > 0) begin
          void'(tree_q.pop_back());
          tree_q.push_back(int'(bus.tq_data));
          tree_q.sort();
        end else if (bus.tq_data != 0) begin
          tree_q.push_back(int'(bus.tq_data));
        end
      end
      bus.tq_root <= (tree_q.size() > 0) ? 16'(tree_q[$]) : 16'd0;
    end
  end

  // Reference state
  int          ref_q[$];
  int          ptr_m = 0;
  bit          pend[2];
  logic [1:0]  p_op[2];
  logic [15:0] p_data[2];
  bit          exp_out = 0, rsp_first = 0;
  int          exp_id = 0, exp_pulse = 0, pulses = 0;
  logic [15:0] exp_data = 0, exp_tqd = 0;
  logic        exp_err = 0, exp_w = 0, exp_r = 0;
  int          cyc = 0, grant_cyc = 0, last_issue = -100, drop = -1;
  int          grant_log[$];
  int          hold_low = 0, rdy_pct = 100, rsp_vcyc = 0, max_vcyc = 0;
  logic [15:0] last_data = 0;
  int          last_id = 0;
  logic        last_err = 0;

  function automatic int pred_winner(input logic [1:0] v, input int p);
    for (int i = 0; i < 2; i++) begin
      int k;
      k = (p + i) % 2;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic ref_apply(input int w);
    logic [1:0] op;
    logic [15:0] d;
    int c;
    op = p_op[w]; d = p_data[w]; c = ref_q.size();
    exp_out = 1; rsp_first = 1; exp_id = w; exp_data = 0; exp_err = 0;
    pulses = 0; rsp_vcyc = 0;
    exp_w = op[0]; exp_r = op[1]; exp_tqd = d;
    if (op == 2'b00 || (op == 2'b10 && c == 0) || (op == 2'b01 && c == 7)) begin
      exp_err = 1; exp_pulse = 0;
    end else begin
      exp_pulse = 1;
      if (op[1] && c > 0) begin
        exp_data = 16'(ref_q[$]);
        void'(ref_q.pop_back());
      end
      if (op == 2'b01 || (op == 2'b11 && (c > 0 || d != 0))) begin
        ref_q.push_back(int'(d));
        ref_q.sort();
      end
    end
  endtask

  task automatic step();
    logic [1:0] vseen;
    @(negedge CLK);
    cyc++;
    vseen = bus.req_valid;
    if (drop >= 0) begin pend[drop] = 1'b0; drop = -1; end
    if (bus.req_ready != 2'b00) begin
      int w;
      w = pred_winner(vseen, ptr_m);
      chk("grant_onehot", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
      chk("grant_while_rsp", 32'(bus.rsp_valid), 32'd0);
      if (w >= 0) begin
        ref_apply(w);
        grant_log.push_back(w);
        ptr_m = (w + 1) % 2;
        drop = w;
        grant_cyc = cyc;
      end
    end
    if (bus.tq_wrt || bus.tq_read) begin
      pulses++;
      chk("tq_wrt", 32'(bus.tq_wrt), 32'(exp_w));
      chk("tq_read", 32'(bus.tq_read), 32'(exp_r));
      chk("tq_data", 32'(bus.tq_data), 32'(exp_tqd));
      chk("tq_spacing", 32'(cyc - last_issue >= 6), 32'd1);
      last_issue = cyc;
    end
    if (bus.rsp_valid) begin
      chk("rsp_expected", 32'(exp_out), 32'd1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
      chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      rsp_vcyc++;
      if (rsp_first) begin
        rsp_first = 0;
        chk("tq_pulses", 32'(pulses), 32'(exp_pulse));
        chk("count", 32'(bus.count), 32'(ref_q.size()));
        chk("rsp_latency", 32'(cyc - grant_cyc), 32'd2);
      end
      if (hold_low > 0) begin
        hold_low--;
        bus.rsp_ready = 1'b0;
      end else begin
        bus.rsp_ready = ($urandom_range(99) < rdy_pct);
      end
      if (bus.rsp_ready) begin
        exp_out = 0;
        last_data = bus.rsp_data; last_id = int'(bus.rsp_id); last_err = bus.rsp_err;
        if (rsp_vcyc > max_vcyc) max_vcyc = rsp_vcyc;
      end
    end else begin
      bus.rsp_ready = 1'b0;
    end
    for (int r = 0; r < 2; r++) begin
      bus.req_valid[r]        = pend[r];
      bus.req_op[2*r +: 2]    = p_op[r];
      bus.req_data[16*r +: 16] = p_data[r];
    end
  endtask

  task automatic post(input int r, input logic [1:0] op, input logic [15:0] d);
    int n = 0;
    while (pend[r] && n < 300) begin step(); n++; end
    if (n >= 300) chk("post_timeout", 32'(pend[r]), 32'd0);
    p_op[r] = op; p_data[r] = d; pend[r] = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0] || pend[1] || exp_out) && n < 500) begin step(); n++; end
    chk("drain_timeout", 32'(pend[0] || pend[1] || exp_out), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0; bus.req_op = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
    pend[0] = 0; pend[1] = 0;
    p_op[0] = 0; p_op[1] = 0; p_data[0] = 0; p_data[1] = 0;
    repeat (3) step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_bits", {bus.rsp_data, 15'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_tq", {bus.tq_data, 14'd0, bus.tq_wrt, bus.tq_read}, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    RSTn = 1'b1;
    repeat (2) step();

    // Three pushes from requester 0
    post(0, 2'b01, 16'd5); post(0, 2'b01, 16'd9); post(0, 2'b01, 16'd3);
    drain();
    chk("push3_count", 32'(bus.count), 32'd3);
    chk("push3_err", 32'(last_err), 32'd0);

    // Pop from requester 1 returns the largest key
    post(1, 2'b10, 16'd0);
    drain();
    chk("pop_data", 32'(last_data), 32'd9);
    chk("pop_id", 32'(last_id), 32'd1);
    chk("pop_count", 32'(bus.count), 32'd2);

    // Empty, then pop on empty
    while (ref_q.size() > 0) begin post(0, 2'b10, 16'd0); drain(); end
    post(0, 2'b10, 16'd0); drain();
    chk("empty_pop_err", 32'(last_err), 32'd1);
    chk("empty_pop_data", 32'(last_data), 32'd0);

    // Fill to capacity, then push at full and an illegal op
    begin
      int n;
      n = 7 - ref_q.size();
      for (int i = 0; i < n; i++) post(0, 2'b01, 16'($urandom_range(1, 200)));
    end
    drain();
    chk("full_count", 32'(bus.count), 32'd7);
    post(0, 2'b01, 16'd77); drain();
    chk("full_push_err", 32'(last_err), 32'd1);
    post(1, 2'b00, 16'd1); drain();
    chk("op00_err", 32'(last_err), 32'd1);
    chk("op00_id", 32'(last_id), 32'd1);

    // Both requesters valid continuously: grants alternate
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      post(0, 2'b11, 16'($urandom_range(1, 300)));
      post(1, 2'b11, 16'($urandom_range(1, 300)));
    end
    drain();
    for (int i = 0; i < 8; i++) chk("alternate", 32'(grant_log[i]), 32'(i % 2));

    // Response held for 10 cycles with another request waiting
    max_vcyc = 0; hold_low = 10;
    post(0, 2'b10, 16'd0); post(1, 2'b10, 16'd0);
    drain();
    chk("hold_rsp_cycles", 32'(max_vcyc >= 11), 32'd1);

    // REPLACE 12 on an empty tree
    while (ref_q.size() > 0) begin post(0, 2'b10, 16'd0); drain(); end
    post(0, 2'b11, 16'd12); drain();
    chk("replace_empty_count", 32'(bus.count), 32'd1);
    chk("replace_empty_data", 32'(last_data), 32'd0);

    // Reset in the middle of the issue gap
    post(0, 2'b01, 16'd7); drain();
    step();
    RSTn = 1'b0;
    step();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_rsp", {bus.rsp_data, 14'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    chk("mid_rst_tq", {bus.tq_data, 14'd0, bus.tq_wrt, bus.tq_read}, 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    ref_q.delete(); ptr_m = 0; exp_out = 0; pulses = 0; last_issue = -100;
    step();
    RSTn = 1'b1;
    repeat (20) step();
    chk("post_rst_no_pulse", 32'(pulses), 32'd0);

    // Randomized traffic
    rdy_pct = 70;
    for (int i = 0; i < 300; i++)
      post($urandom_range(0, 1), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 40)));
    drain();
    chk("final_count", 32'(bus.count), 32'(ref_q.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800us;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
